// File: rtl/tff_mod_counter_pkg.sv
// Shared helpers for the toggle-flip-flop counter family: width math and
// parameter legality checks evaluated at elaboration time.
package tff_mod_counter_pkg;

    // Smallest n with 2**n >= v (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned n;
        longint unsigned p;
        n = 0;
        p = 64'd1;
        while (p < longint'(v)) begin
            p = p << 1;
            n = n + 1;
        end
        return n;
    endfunction

    // 2**w computed wide enough that w up to 63 does not overflow.
    function automatic longint unsigned pow2(input int unsigned w);
        return 64'd1 << w;
    endfunction

    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned modulus,
                                     input int unsigned reset_val);
        bit ok;
        ok = 1'b1;
        if (width < 1) ok = 1'b0;
        if (modulus < 2) ok = 1'b0;
        if (longint'(modulus) > pow2(width)) ok = 1'b0;
        if (reset_val >= modulus) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/tff_bit.sv
// One toggle flip-flop with asynchronous active-low reset to a per-bit value.
// Provides true and complement outputs.
module tff_bit (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic t,
    output logic q,
    output logic qn
);

    logic q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= rst_val;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter assembled from per-bit toggle flip-flops, with
// synchronous saturating load, combinational terminal count and a wrap pulse.
module tff_mod_counter
    import tff_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 16,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap
);

    localparam int unsigned    W1      = WIDTH + 1;
    localparam logic [WIDTH:0] ModMax  = W1'(MODULUS - 1);
    localparam logic [WIDTH:0] ModVal  = W1'(MODULUS);
    localparam logic [WIDTH-1:0] RstVec = WIDTH'(RESET_VAL);

    if (!params_ok(WIDTH, MODULUS, RESET_VAL)) begin : g_bad_params
        $error("tff_mod_counter: illegal WIDTH=%0d MODULUS=%0d RESET_VAL=%0d",
               WIDTH, MODULUS, RESET_VAL);
    end

    // One extra bit keeps q+1 and the MODULUS compare exact when MODULUS == 2**WIDTH.
    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   d_sat;
    logic [WIDTH:0]   q_next;
    logic [WIDTH-1:0] t;
    logic             at_max;
    logic             at_zero;
    logic             unused_q_next_msb;

    assign q_ext   = {1'b0, q};
    assign d_ext   = {1'b0, d};
    assign d_sat   = (d_ext < ModVal) ? d_ext : ModMax;
    assign at_max  = (q_ext == ModMax);
    assign at_zero = (q_ext == '0);

    always_comb begin
        q_next = q_ext;
        if (load) begin
            q_next = d_sat;
        end else if (en) begin
            if (up) begin
                q_next = at_max ? '0 : q_ext + W1'(1);
            end else begin
                q_next = at_zero ? ModMax : q_ext - W1'(1);
            end
        end
    end

    // Reachable q_next never exceeds MODULUS-1, so the top bit is always zero.
    assign unused_q_next_msb = q_next[WIDTH];
    assign t                 = q ^ q_next[WIDTH-1:0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_bit u_bit (
            .clk     (clk),
            .reset   (reset),
            .rst_val (RstVec[i]),
            .t       (t[i]),
            .q       (q[i]),
            .qn      (qn[i])
        );
    end

    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Directed bench for tff_mod_counter at WIDTH=4, MODULUS=10, RESET_VAL=0.
module tb_tff_mod_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;
    logic             wrap;

    int vectors;
    int miscompares;

    tff_mod_counter #(
        .WIDTH     (4),
        .MODULUS   (10),
        .RESET_VAL (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .up    (up),
        .load  (load),
        .d     (d),
        .q     (q),
        .qn    (qn),
        .tc    (tc),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        en    = 1'b0;
        up    = 1'b1;
        load  = 1'b0;
        d     = '0;

        #12;
        check("por_q", 32'(q), 32'h0);
        check("por_qn", 32'(qn), 32'hF);
        check("por_wrap", 32'(wrap), 32'h0);

        // Test 1: reach q=5, then async reset mid-cycle.
        reset = 1'b1;
        load  = 1'b1;
        d     = 4'd5;
        step();
        check("load5_q", 32'(q), 32'h5);
        load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_q", 32'(q), 32'h0);
        check("async_rst_qn", 32'(qn), 32'hF);
        check("async_rst_wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        check("rst_held_q", 32'(q), 32'h0);
        reset = 1'b1;
        en    = 1'b1;
        up    = 1'b1;
        step();
        check("first_edge_q", 32'(q), 32'h1);

        // Test 2: count up through the wrap from 0.
        load = 1'b1;
        d    = 4'd0;
        step();
        check("load0_q", 32'(q), 32'h0);
        load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check($sformatf("up_tc_%0d", k - 1), 32'(tc), (k == 10) ? 32'h1 : 32'h0);
            step();
            check($sformatf("up_q_%0d", k), 32'(q), 32'(k % 10));
            check($sformatf("up_qn_%0d", k), 32'(qn), 32'(~(k % 10) & 4'hF));
            check($sformatf("up_wrap_%0d", k), 32'(wrap), (k == 10) ? 32'h1 : 32'h0);
        end

        // Test 3: down from 0 wraps to 9.
        en = 1'b0;
        step();
        check("hold0_q", 32'(q), 32'h0);
        check("hold0_wrap", 32'(wrap), 32'h0);
        en = 1'b1;
        up = 1'b0;
        #1;
        check("dn_tc0", 32'(tc), 32'h1);
        step();
        check("dn_q9", 32'(q), 32'h9);
        check("dn_wrap9", 32'(wrap), 32'h1);
        check("dn_tc9", 32'(tc), 32'h0);
        step();
        check("dn_q8", 32'(q), 32'h8);
        check("dn_wrap8", 32'(wrap), 32'h0);
        step();
        check("dn_q7", 32'(q), 32'h7);

        // Test 4: load in range and saturating load.
        up   = 1'b1;
        load = 1'b1;
        d    = 4'd7;
        #1;
        check("ld7_tc_pre", 32'(tc), 32'h0);
        step();
        check("ld7_q", 32'(q), 32'h7);
        check("ld7_tc", 32'(tc), 32'h0);
        d = 4'd12;
        step();
        check("ld12_q", 32'(q), 32'h9);
        check("ld12_wrap", 32'(wrap), 32'h0);
        d = 4'd10;
        step();
        check("ld10_q", 32'(q), 32'h9);

        // Test 5: hold at 3 with up toggling.
        d = 4'd3;
        step();
        check("ld3_q", 32'(q), 32'h3);
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            up = i[0];
            #1;
            check($sformatf("hold_tc_%0d", i), 32'(tc), 32'h0);
            step();
            check($sformatf("hold_q_%0d", i), 32'(q), 32'h3);
            check($sformatf("hold_wrap_%0d", i), 32'(wrap), 32'h0);
        end

        // Test 6: load beats a pending wrap.
        load = 1'b1;
        d    = 4'd9;
        step();
        check("ld9_q", 32'(q), 32'h9);
        up   = 1'b1;
        en   = 1'b1;
        d    = 4'd4;
        #1;
        check("ldwin_tc", 32'(tc), 32'h0);
        step();
        check("ldwin_q", 32'(q), 32'h4);
        check("ldwin_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        step();
        check("after_q", 32'(q), 32'h5);
        check("after_qn", 32'(qn), 32'hA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
